// File: rtl/cla_pkg.sv
// Shared types and constants for the carry-lookahead adder family.
package cla_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} cla_ser_state_t;

  localparam int CLA_BLK_W = 4;

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead slice with block propagate/generate outputs.
module cla_4bit
  import cla_pkg::*;
(
  input  logic [CLA_BLK_W-1:0] a,
  input  logic [CLA_BLK_W-1:0] b,
  input  logic                 cin,
  output logic [CLA_BLK_W-1:0] sum,
  output logic                 cout,
  output logic                 P_blk,
  output logic                 G_blk
);

  logic [CLA_BLK_W-1:0] w_p;
  logic [CLA_BLK_W-1:0] w_g;
  logic [CLA_BLK_W:0]   w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Every carry is expanded from c0 directly, so there is no ripple inside the slice.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = G_blk | (P_blk & cin);

  assign P_blk = &w_p;
  assign G_blk = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

  assign sum  = w_p ^ w_c[CLA_BLK_W-1:0];
  assign cout = w_c[CLA_BLK_W];

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// Digit-serial adder: one 4-bit CLA slice per clock, carry rippled through a register.
module cla_nibble_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / CLA_BLK_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (WIDTH < CLA_BLK_W || (WIDTH % CLA_BLK_W) != 0) begin : g_bad_width
      $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  cla_ser_state_t r_state, w_next;

  logic [NIB-1:0][CLA_BLK_W-1:0] r_a, r_b, r_res;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_carry, r_cout, r_ovf;

  logic [CLA_BLK_W-1:0] w_sum;
  logic                 w_cout, w_last, w_accept, w_ovf;
  logic                 w_unused_p, w_unused_g;

  cla_4bit u_cla (
    .a     (r_a[r_cnt]),
    .b     (r_b[r_cnt]),
    .cin   (r_carry),
    .sum   (w_sum),
    .cout  (w_cout),
    .P_blk (w_unused_p),
    .G_blk (w_unused_g)
  );

  assign w_last   = (r_cnt == CNT_W'(NIB - 1));
  assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_ovf    = (r_a[NIB-1][CLA_BLK_W-1] == r_b[NIB-1][CLA_BLK_W-1])
                  & (w_sum[CLA_BLK_W-1] != r_a[NIB-1][CLA_BLK_W-1]);

  assign out_valid = (r_state == DONE);
  assign sum       = r_res;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = BUSY;
      BUSY:    if (w_last)   w_next = DONE;
      DONE:    if (out_ready) w_next = in_valid ? BUSY : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == BUSY) begin
      r_res[r_cnt] <= w_sum;
      r_carry      <= w_cout;
      // Counter parks on the last slice; the accept path rewinds it.
      if (w_last) begin
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed bench for the serial CLA adder: WIDTH=16 main instance plus a WIDTH=4 smoke instance.
module tb_cla_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cin;
  logic [15:0] a, b;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;

  logic       s_in_valid, s_cin;
  logic [3:0] s_a, s_b;
  logic       s_in_ready, s_out_valid, s_cout, s_ovf;
  logic [3:0] s_sum;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .out_valid(s_out_valid), .out_ready(out_ready),
    .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step until out_valid rises (bounded); returns cycles spent.
  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                     input logic tc, input logic [15:0] es, input logic ec, input logic eo);
    int n;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
    wait_out(tag, n);
    chk({tag, "_lat"}, 32'(n), 32'd4);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    step();
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n, t0, t1, t2;
    logic [15:0] hold_sum;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run("t1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run("t2a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run("t2b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run("t3a", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run("t3b", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

    // Back-to-back with in_valid held high.
    in_valid = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
    step();
    a = 16'h1111; b = 16'h2222;
    wait_out("bb0", n); t0 = cyc;
    chk("bb0_sum", 32'(sum), 32'h0003);
    chk("bb0_in_ready", 32'(in_ready), 32'd1);
    step();
    a = 16'hF000; b = 16'h1000;
    wait_out("bb1", n); t1 = cyc;
    chk("bb1_sum", 32'(sum), 32'h3333);
    chk("bb1_gap", 32'(t1 - t0), 32'd5);
    step();
    in_valid = 1'b0;
    wait_out("bb2", n); t2 = cyc;
    chk("bb2_sum", 32'(sum), 32'h0000);
    chk("bb2_cout", 32'(cout), 32'd1);
    chk("bb2_gap", 32'(t2 - t1), 32'd5);
    step();
    chk("bb_drain", 32'(out_valid), 32'd0);

    // Stall in DONE with new operands offered.
    out_ready = 1'b0;
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out("st", n);
    hold_sum = sum;
    chk("st_sum", 32'(sum), 32'hBCDE);
    in_valid = 1'b1; a = 16'h0F0F; b = 16'h0F0F;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("st_valid", 32'(out_valid), 32'd1);
      chk("st_hold", {15'd0, cout, hold_sum}, {15'd0, 1'b0, 16'hBCDE});
      chk("st_sum_stable", 32'(sum), 32'hBCDE);
      chk("st_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("st_release_ready", 32'(in_ready), 32'd1);
    step();
    chk("st_single", 32'(out_valid), 32'd0);
    step();
    chk("st_stay_idle", 32'(out_valid), 32'd0);

    // Reset mid-operation discards it.
    a = 16'h1234; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_sum", 32'(sum), 32'd0);
    chk("mr_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mr_no_out", 32'(out_valid), 32'd0);
    end
    run("t6", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // WIDTH=4 smoke test.
    s_a = 4'hF; s_b = 4'h1; s_cin = 1'b0; s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 10) begin
      step();
      n++;
    end
    chk("w4_lat", 32'(n), 32'd1);
    chk("w4_sum", 32'(s_sum), 32'h0);
    chk("w4_cout", 32'(s_cout), 32'd1);
    chk("w4_ovf", 32'(s_ovf), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
